if_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 15 +
 rtl/if_id_reg.sv | 43 ++++
 rtl/if_stage.sv | 119 +++++++++++
 tb/tb_if_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Fetch FSM encoding, XLEN and the NOP/EBREAK encodings.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_st_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and flush.
// Flush wins over hold; load is ignored while flushing.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_load,
  input  logic         i_flush,
  input  logic [W-1:0] i_pc,
  input  logic [W-1:0] i_inst,
  output logic         o_valid,
  output logic [W-1:0] o_pc,
  output logic [W-1:0] o_inst
);

  logic         r_valid;
  logic [W-1:0] r_pc;
  logic [W-1:0] r_inst;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= W'(NOP_INST);
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= W'(NOP_INST);
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, next-PC select, halt FSM, IF/ID register.
// IF_PERF_CNT_EN adds saturating fetch/stall counters.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] inst_in,
  output logic [XLEN-1:0] PC_out,
  output logic            IF_ID_valid,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [XLEN-1:0] IF_ID_Inst,
  output logic            halted,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     stall_cnt,
`endif
  output logic            misalign
);

  fetch_st_e       r_state;
  fetch_st_e       w_nstate;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_mis;
  logic            w_mis;
  logic            w_load;
  logic            w_flush;
  logic            w_adv;
  logic            w_stl;
  logic            w_ebrk;

  assign w_ebrk = IF_ID_valid &&
                  (IF_ID_Inst == XLEN'(EBREAK_INST));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= RUN;
      r_pc    <= XLEN'(RESET_PC);
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_pc    <= w_pc_nxt;
      r_mis   <= r_mis | w_mis;
    end
  end

  // Redirect > stall > EBREAK halt > advance.
  always_comb begin
    w_nstate = r_state;
    w_pc_nxt = r_pc;
    w_load   = 1'b0;
    w_flush  = 1'b0;
    w_adv    = 1'b0;
    w_stl    = 1'b0;
    w_mis    = 1'b0;
    if (r_state == RUN) begin
      if (redirect) begin
        w_pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
        w_flush  = 1'b1;
        w_mis    = |redirect_pc[1:0];
      end else if (stall) begin
        w_stl = 1'b1;
      end else if (w_ebrk) begin
        w_flush  = 1'b1;
        w_nstate = HALT;
      end else begin
        w_pc_nxt = r_pc + XLEN'(4);
        w_load   = 1'b1;
        w_adv    = 1'b1;
      end
    end
  end

  if_id_reg #(
    .W(XLEN)
  ) u_if_id (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_load),
    .i_flush(w_flush),
    .i_pc   (r_pc),
    .i_inst (inst_in),
    .o_valid(IF_ID_valid),
    .o_pc   (IF_ID_PC),
    .o_inst (IF_ID_Inst)
  );

  assign PC_out   = r_pc;
  assign halted   = (r_state == HALT);
  assign misalign = r_mis;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fcnt;
  logic [31:0] r_scnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fcnt <= '0;
      r_scnt <= '0;
    end else begin
      if (w_adv && (r_fcnt != 32'hFFFF_FFFF))
        r_fcnt <= r_fcnt + 32'd1;
      if (w_stl && (r_scnt != 32'hFFFF_FFFF))
        r_scnt <= r_scnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fcnt;
  assign stall_cnt = r_scnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage.
// Models instruction memory as a 256-word combinational array.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_in;
  logic [31:0] PC_out;
  logic        IF_ID_valid;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_Inst;
  logic        halted;
  logic        misalign;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  logic [31:0] mem [0:255];
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign inst_in = mem[PC_out[9:2]];

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .XLEN    (32)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_in    (inst_in),
    .PC_out     (PC_out),
    .IF_ID_valid(IF_ID_valid),
    .IF_ID_PC   (IF_ID_PC),
    .IF_ID_Inst (IF_ID_Inst),
    .halted     (halted),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .misalign   (misalign)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag,
                          input logic v,
                          input logic [31:0] pc,
                          input logic [31:0] ins);
    check({tag, ".v"}, 32'(IF_ID_valid), 32'(v));
    check({tag, ".pc"}, IF_ID_PC, pc);
    check({tag, ".in"}, IF_ID_Inst, ins);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = 32'hA000_0000 + 32'(i);
    rstn        = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    #12;
    check("rst.pc", PC_out, 32'h0);
    chk_ifid("rst", 1'b0, 32'h0, NOP);
    check("rst.halt", 32'(halted), 32'h0);
    check("rst.mis", 32'(misalign), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // sequential fetch
    tick();
    check("seq.pc4", PC_out, 32'h4);
    chk_ifid("seq1", 1'b1, 32'h0, mem[0]);
    tick();
    check("seq.pc8", PC_out, 32'h8);
    chk_ifid("seq2", 1'b1, 32'h4, mem[1]);

    // stall two cycles at PC=8
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stl.pc", PC_out, 32'h8);
      chk_ifid("stl", 1'b1, 32'h4, mem[1]);
    end
    stall = 1'b0;
    tick();
    check("stl.pcC", PC_out, 32'hC);
    chk_ifid("stl3", 1'b1, 32'h8, mem[2]);

    // redirect overrides stall
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    stall       = 1'b1;
    tick();
    check("rds.pc", PC_out, 32'h100);
    chk_ifid("rds", 1'b0, 32'h0, NOP);
    redirect = 1'b0;
    stall    = 1'b0;
    tick();
    check("rds.pc2", PC_out, 32'h104);
    chk_ifid("rds2", 1'b1, 32'h100, mem[64]);
    check("rds.mis", 32'(misalign), 32'h0);

    // misaligned redirect
    redirect    = 1'b1;
    redirect_pc = 32'h202;
    tick();
    redirect = 1'b0;
    check("mis.pc", PC_out, 32'h200);
    check("mis.flag", 32'(misalign), 32'h1);
    for (int i = 0; i < 10; i++) tick();
    check("mis.sticky", 32'(misalign), 32'h1);
    check("mis.pc10", PC_out, 32'h228);

    // EBREAK halt; async reset checked without a clock edge
    mem[4] = EBK;
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("arst.pc", PC_out, 32'h0);
    check("arst.mis", 32'(misalign), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("ebk.pc", PC_out, 32'h14);
    chk_ifid("ebk.in", 1'b1, 32'h10, EBK);
    check("ebk.h0", 32'(halted), 32'h0);
    tick();
    check("ebk.halt", 32'(halted), 32'h1);
    check("ebk.v", 32'(IF_ID_valid), 32'h0);
    check("ebk.pcf", PC_out, 32'h14);
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    tick();
    tick();
    redirect = 1'b0;
    check("hlt.pc", PC_out, 32'h14);
    check("hlt.halt", 32'(halted), 32'h1);
    check("hlt.v", 32'(IF_ID_valid), 32'h0);
    check("hlt.mis", 32'(misalign), 32'h0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("hrst.pc", PC_out, 32'h0);
    check("hrst.halt", 32'(halted), 32'h0);

    // EBREAK on wrong path, with a stall first
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk_ifid("wp.in", 1'b1, 32'h10, EBK);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    check("wp.stlh", 32'(halted), 32'h0);
    check("wp.stlpc", PC_out, 32'h14);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    check("wp.halt", 32'(halted), 32'h0);
    check("wp.pc", PC_out, 32'h40);
    check("wp.v", 32'(IF_ID_valid), 32'h0);
    tick();
    check("wp.pc2", PC_out, 32'h44);
    chk_ifid("wp2", 1'b1, 32'h40, mem[16]);
`ifdef IF_PERF_CNT_EN
    check("perf.fetch", fetch_cnt, 32'd6);
    check("perf.stall", stall_cnt, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
